// File: rtl/pipeline_skid_register.sv
// Elastic valid/ready pipeline built from a chain of 2-entry skid stages.
// Every stage's ready comes from its state register, so no combinational path runs from OUT_READY to IN_READY.
module pipeline_skid_register #(
    parameter int NUM_STAGES = 1,
    parameter int DATA_WIDTH = 1,
    localparam int CNT_W = (NUM_STAGES == 0) ? 1 : $clog2(2 * NUM_STAGES + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [CNT_W-1:0]      COUNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_e;

    if (NUM_STAGES == 0) begin : g_pass
        assign OUT_VALID = IN_VALID;
        assign OUT_DATA  = IN_DATA;
        assign IN_READY  = OUT_READY;
        assign COUNT     = '0;
    end else begin : g_pipe
        localparam logic [CNT_W-1:0] CNT_ONE = 1;

        // Chain index k is the input side of stage k; index NUM_STAGES is the block output.
        logic [NUM_STAGES:0]   v_chain;
        logic [NUM_STAGES:0]   r_chain;
        logic [DATA_WIDTH-1:0] d_chain [NUM_STAGES+1];

        logic             in_xfer;
        logic             out_xfer;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;

        assign v_chain[0]          = IN_VALID;
        assign d_chain[0]          = IN_DATA;
        assign r_chain[NUM_STAGES] = OUT_READY;

        assign IN_READY  = r_chain[0];
        assign OUT_VALID = v_chain[NUM_STAGES];
        assign OUT_DATA  = d_chain[NUM_STAGES];
        assign COUNT     = count_q;

        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            stage_e                state_q;
            stage_e                state_d;
            logic [DATA_WIDTH-1:0] main_q;
            logic [DATA_WIDTH-1:0] main_d;
            logic [DATA_WIDTH-1:0] skid_q;
            logic [DATA_WIDTH-1:0] skid_d;
            logic                  acc;
            logic                  take;

            assign acc  = v_chain[k] & (state_q != FULL);
            assign take = (state_q != EMPTY) & r_chain[k+1];

            assign r_chain[k]   = (state_q != FULL);
            assign v_chain[k+1] = (state_q != EMPTY);
            assign d_chain[k+1] = main_q;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            // main always holds the oldest word; skid only catches the one extra word on a stall.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    EMPTY: begin
                        if (acc) begin
                            state_d = BUSY;
                            main_d  = d_chain[k];
                        end
                    end
                    BUSY: begin
                        if (acc && !take) begin
                            state_d = FULL;
                            skid_d  = d_chain[k];
                        end else if (acc && take) begin
                            main_d = d_chain[k];
                        end else if (take) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (take) begin
                            state_d = BUSY;
                            main_d  = skid_q;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign in_xfer  = IN_VALID & r_chain[0];
        assign out_xfer = v_chain[NUM_STAGES] & OUT_READY;

        always_ff @(posedge CLK) begin
            if (RESET) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        always_comb begin
            count_d = count_q;
            case ({in_xfer, out_xfer})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed and scoreboarded checks of a 3-stage 8-bit skid pipeline plus a 0-stage passthrough.
module tb_pipeline_skid_register;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    logic       p_in_valid;
    logic       p_in_ready;
    logic [7:0] p_in_data;
    logic       p_out_valid;
    logic       p_out_ready;
    logic [7:0] p_out_data;
    logic [0:0] p_count;

    int checks = 0;
    int errors = 0;

    pipeline_skid_register #(.NUM_STAGES(3), .DATA_WIDTH(8)) u_dut (
        .CLK(clk), .RESET(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .COUNT(count)
    );

    pipeline_skid_register #(.NUM_STAGES(0), .DATA_WIDTH(8)) u_pass (
        .CLK(clk), .RESET(rst),
        .IN_VALID(p_in_valid), .IN_READY(p_in_ready), .IN_DATA(p_in_data),
        .OUT_VALID(p_out_valid), .OUT_READY(p_out_ready), .OUT_DATA(p_out_data),
        .COUNT(p_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h exp 00", out_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_stream();
        int  nxt = 1;
        int  got = 0;
        int  first_out = -1;
        bit  acc;
        bit  take;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 16; c++) begin
            in_valid = (nxt <= 16);
            in_data  = 8'(nxt);
            #1;
            checks++; if (in_valid && in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cycle %0d got %0b exp 1", c, in_ready); end
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) begin
                checks++; if (out_data !== 8'(got + 1)) begin errors++; $display("FAIL stream_order got %0h exp %0h", out_data, 8'(got + 1)); end
                got++;
            end
            tick();
            if (acc) nxt++;
            if (out_valid === 1'b1 && first_out < 0) first_out = c;
            if (c >= 2 && c <= 15) begin
                checks++; if (count !== 3'd3) begin errors++; $display("FAIL stream_count cycle %0d got %0d exp 3", c, count); end
            end
            if (c >= 2 && got < 16) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap cycle %0d got %0b exp 1", c, out_valid); end
            end
        end
        in_valid = 1'b0;
        checks++; if (first_out != 2) begin errors++; $display("FAIL stream_latency got %0d exp 2", first_out); end
        checks++; if (got != 16) begin errors++; $display("FAIL stream_words got %0d exp 16", got); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_fill();
        int acc_n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h21 + acc_n);
            #1;
            if (in_ready === 1'b1) acc_n++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (acc_n != 6) begin errors++; $display("FAIL fill_accepted got %0d exp 6", acc_n); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0b exp 0", in_ready); end
        checks++; if (count !== 3'd6) begin errors++; $display("FAIL fill_count got %0d exp 6", count); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin errors++; $display("FAIL fill_head got %0b/%0h exp 1/21", out_valid, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'h21 + i)) begin errors++; $display("FAIL drain_word %0d got %0b/%0h exp 1/%0h", i, out_valid, out_data, 8'(8'h21 + i)); end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %0b exp 0", out_valid); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] exp_w;
        logic [7:0] prev_data = 8'h00;
        bit  prev_stall = 1'b0;
        bit  pending = 1'b0;
        bit  acc;
        bit  take;
        int  sent = 0;
        int  recv = 0;
        int  model_cnt = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 20000 && recv < 1000; c++) begin
            if (!pending) begin
                in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
                in_data  = 8'($urandom_range(0, 255));
            end
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin errors++; $display("FAIL rand_stall_hold got %0b/%0h exp 1/%0h", out_valid, out_data, prev_data); end
            end
            acc  = in_valid && (in_ready === 1'b1);
            take = (out_valid === 1'b1) && out_ready;
            if (take) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL rand_extra_word got %0h exp none", out_data);
                end else begin
                    exp_w = q.pop_front();
                    checks++; if (out_data !== exp_w) begin errors++; $display("FAIL rand_data got %0h exp %0h", out_data, exp_w); end
                end
                recv++;
            end
            if (acc) begin
                q.push_back(in_data);
                sent++;
            end
            pending    = in_valid && !acc;
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            model_cnt  = model_cnt + int'(acc) - int'(take);
            tick();
            checks++; if (count !== 3'(model_cnt)) begin errors++; $display("FAIL rand_count cycle %0d got %0d exp %0d", c, count, model_cnt); end
        end
        in_valid = 1'b0;
        checks++; if (recv != 1000 || q.size() != 0) begin errors++; $display("FAIL rand_total got %0d left %0d exp 1000 left 0", recv, q.size()); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h51 + i);
            tick();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL midrst_pre_count got %0d exp 4", count); end
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %0b exp 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL midrst_out_data got %0h exp 00", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0b exp 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_ghost_words got %0d exp 0", seen); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_post_count got %0d exp 0", count); end
    endtask

    task automatic test_passthrough();
        logic       exp_rdy;
        logic       exp_vld;
        logic [7:0] exp_dat;
        for (int i = 0; i < 6; i++) begin
            exp_rdy = i[0];
            exp_vld = i[1];
            exp_dat = 8'(8'h3C ^ (i * 17));
            p_out_ready = exp_rdy;
            p_in_valid  = exp_vld;
            p_in_data   = exp_dat;
            #2;
            checks++; if (p_in_ready !== exp_rdy) begin errors++; $display("FAIL pass_in_ready vec %0d got %0b exp %0b", i, p_in_ready, exp_rdy); end
            checks++; if (p_out_valid !== exp_vld) begin errors++; $display("FAIL pass_out_valid vec %0d got %0b exp %0b", i, p_out_valid, exp_vld); end
            checks++; if (p_out_data !== exp_dat) begin errors++; $display("FAIL pass_out_data vec %0d got %0h exp %0h", i, p_out_data, exp_dat); end
            checks++; if (p_count !== 1'b0) begin errors++; $display("FAIL pass_count vec %0d got %0d exp 0", i, p_count); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        p_in_valid = 1'b0; p_in_data = 8'h00; p_out_ready = 1'b0;
        test_reset();
        test_stream();
        test_fill();
        test_random();
        test_reset_mid();
        test_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
